mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Parametrised successor of the pipeline memory stage.
- Replaces the fixed-word, wait-only cache coupling with a valid/ready request and response handshake to the cache controller.
- Adds RISC-V sub-word loads and stores: byte/half/word (plus double and unsigned-word when XLEN=64), with byte enables and sign/zero extension.
- Adds misalignment detection, a response watchdog, and the MEM/WB pipeline register. Sits between the execute stage and writeback; its stall output drives the hazard unit.

Parameters:
- XLEN, 32, data/register width; legal values 32 or 64.
- ADDR_W, 32, byte address width sent to the cache.
- RD_W, 5, destination register index width.
- TIMEOUT, 255, maximum cycles spent in WAIT before bus-error release; 0 disables the watchdog.

Ports:
- clk  in  1  stage clock
- rst  in  1  synchronous active-low reset
- RegwriteM  in  1  register write enable
- ResultSrcM  in  2  writeback mux select
- MemwriteM  in  1  store
- MemreadM  in  1  load
- Funct3M  in  3  access size/sign
- RdM  in  RD_W  destination register
- ALUResultM  in  XLEN  effective address / ALU result
- WriteDataM  in  XLEN  store data
- pc_plus4M  in  XLEN  return address
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  cache accepts request
- mem_req_we  out  1  write request
- mem_req_addr  out  ADDR_W  word-aligned address
- mem_req_wdata  out  XLEN  lane-aligned store data
- mem_req_be  out  XLEN/8  byte enables
- mem_resp_valid  in  1  response / write acknowledge
- mem_resp_rdata  in  XLEN  raw read word
- MemStall  out  1  hold IF/ID/EX and M inputs
- RegwriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, pc_plus4W  out  MEM/WB register outputs
- MisalignW  out  1  trap flag for the writeback instruction
- BusErrW  out  1  watchdog-expiry flag for the writeback instruction

Behaviour:
- Reset: clk and rst are the single clock and the synchronous active-low reset. rst=0 sampled at posedge → state IDLE, watchdog cleared, all W outputs 0. mem_req_valid is combinationally forced 0 while rst=0. Applies mid-transaction; an outstanding response arriving after reset is ignored.
- access = MemreadM | MemwriteM.
- Illegal Funct3 (011/110 when XLEN=32; 111 always) or a misaligned address (half: addr[0]≠0; word: addr[1:0]≠0; double: addr[2:0]≠0) → "bad". No request is issued, no stall. The instruction passes to W with RegwriteW=0 and MisalignW=1.
- Non-access or bad instructions: pass through in 1 cycle, MemStall=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, access & !bad: mem_req_valid=1 combinationally. mem_req_ready=1 → WAIT; else → REQ.
  - REQ: mem_req_valid held high with stable fields until ready; then → WAIT.
  - WAIT: mem_req_valid=0. mem_resp_valid=1 → MEM/WB captures, → IDLE. mem_resp_valid is ignored in IDLE and REQ.
- MemStall = access & !bad & !(state==WAIT & mem_resp_valid). The MEM/WB register loads only when MemStall=0.
- Minimum memory-op latency is 2 cycles: issue with ready, then response the next cycle.
- Request fields: mem_req_addr = address with the low log2(XLEN/8) bits cleared. Store data is replicated across lanes (byte → every byte, half → every half). mem_req_be is one-hot by size/offset: SB addr=..1 gives be=0010 (XLEN=32); SW gives 1111.
- Load extract: select the lane by offset. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD is a full word. Stores write ReadDataW=0.
- Watchdog: counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT without a response: → IDLE, stall released, instruction retires with RegwriteW=0 and BusErrW=1. A response that arrives on the same edge as expiry wins: normal retire, BusErrW=0.
- MisalignW and BusErrW are 1-cycle-per-instruction registered flags; they clear with the next MEM/WB load.

Decomposition:
- mem_stage_pkg: Funct3 encodings (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU), state enum, and the size→alignment-mask constant.
- One combinational sub-module, lsu_align: computes be, wdata replication, bad, and the load extract/extend.
- FSM, watchdog, and MEM/WB register live in mem_stage_lsu.

Test Plan:
- Non-memory ALU op, RdM=5, ALUResultM=0x1234 → next cycle RegwriteW=1, RdW=5, ALUResultW=0x1234, MemStall never high.
- LB addr 0x103, ready=1, resp next cycle with rdata=0x80000000 → mem_req_addr=0x100, be=1000, MemStall high exactly 1 cycle, ReadDataW=0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH addr 0x102, data 0xABCD, ready low for 3 cycles → valid/fields stable 3 cycles in REQ, wdata=0xABCDABCD, be=1100, retire after resp with RegwriteW=0.
- LW addr 0x102 → no mem_req_valid, no stall, MisalignW=1, RegwriteW=0 next cycle.
- TIMEOUT=4, LW with no response → stall exactly 1+4 cycles, then BusErrW=1, RegwriteW=0, state IDLE. Second run with resp on the expiry cycle → normal retire, BusErrW=0.
- rst=0 asserted while in WAIT → next cycle all W outputs 0 and mem_req_valid=0; a stale resp after release is ignored and no write occurs.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-stage load/store unit:
//   - RISC-V load/store Funct3 encodings
//   - LSU handshake FSM state type
//   - access size (log2 bytes) to address alignment mask table
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Explicit encodings keep the state values identical to the legacy design.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // Indexed by access size (log2 of byte count): low address bits that must be 0.
    localparam logic [2:0] ALIGN_MASK [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

endpackage

// File: rtl/mem_stage_lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational sub-word helper for the memory stage.
// Ports:
//   funct3_i    access size/sign (Funct3)
//   addr_lo_i   low three bits of the effective address
//   wdata_i     store data from the register file
//   rdata_i     raw word returned by the cache
//   be_o        byte enables for the addressed lanes
//   wdata_rep_o store data replicated across all lanes of its size
//   bad_o       illegal Funct3 or misaligned address
//   rdata_ext_o selected load lane, sign- or zero-extended to XLEN
// -----------------------------------------------------------------------------
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [2:0]        addr_lo_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   wdata_rep_o,
    output logic              bad_o,
    output logic [XLEN-1:0]   rdata_ext_o
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    logic [1:0]      size;
    logic [OFFW-1:0] off;
    int unsigned     off_u;
    int unsigned     nbytes;
    int unsigned     nbits;
    logic            illegal;
    logic            misalign;
    logic            msb;
    logic [XLEN-1:0] shifted;

    assign size  = funct3_i[1:0];
    assign off   = addr_lo_i[OFFW-1:0];
    assign off_u = {{(32-OFFW){1'b0}}, off};

    // Doubleword and unsigned-word only exist on RV64.
    assign illegal  = (funct3_i == 3'b111) ||
                      ((XLEN == 32) && ((funct3_i == F3_D) || (funct3_i == F3_WU)));
    assign misalign = |(addr_lo_i & ALIGN_MASK[size]);
    assign bad_o    = illegal | misalign;

    always_comb begin
        nbytes = 32'd1 << size;
        for (int unsigned i = 0; i < NB; i++) begin
            be_o[i] = (i >= off_u) && (i < off_u + nbytes);
        end
    end

    always_comb begin
        case (size)
            2'd0:    wdata_rep_o = {NB{wdata_i[7:0]}};
            2'd1:    wdata_rep_o = {(NB/2){wdata_i[15:0]}};
            2'd2:    wdata_rep_o = {(NB/4){wdata_i[31:0]}};
            default: wdata_rep_o = wdata_i;
        endcase
    end

    // Move the addressed lane down to bit 0, then extend above the access width.
    assign shifted = rdata_i >> {off, 3'b000};

    always_comb begin
        nbits = 32'd8 << size;
        case (size)
            2'd0:    msb = shifted[7];
            2'd1:    msb = shifted[15];
            2'd2:    msb = shifted[31];
            default: msb = shifted[XLEN-1];
        endcase
        // funct3[2] marks the unsigned variants
        msb = msb & ~funct3_i[2];
        for (int unsigned i = 0; i < XLEN; i++) begin
            rdata_ext_o[i] = (i < nbits) ? shifted[i] : msb;
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Pipeline memory stage with valid/ready cache handshake, sub-word loads and
// stores, misalignment trapping, response watchdog and the MEM/WB register.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   *M inputs             instruction fields from the EX/MEM register
//   mem_req_*             request channel to the cache (word-aligned address,
//                         lane-replicated store data, byte enables)
//   mem_resp_valid/rdata  response / write acknowledge from the cache
//   MemStall              holds IF/ID/EX and the M inputs while a request is open
//   *W outputs            MEM/WB register, plus MisalignW / BusErrW trap flags
// -----------------------------------------------------------------------------
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned RD_W    = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegwriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic              MemwriteM,
    input  logic              MemreadM,
    input  logic [2:0]        Funct3M,
    input  logic [RD_W-1:0]   RdM,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [XLEN-1:0]   pc_plus4M,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_be,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    output logic              MemStall,
    output logic              RegwriteW,
    output logic [1:0]        ResultSrcW,
    output logic [RD_W-1:0]   RdW,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   pc_plus4W,
    output logic              MisalignW,
    output logic              BusErrW
);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(XLEN / 8 - 1);

    lsu_state_e      state_q, state_d;
    logic [31:0]     wdog_q, wdog_d;

    logic            access;
    logic            bad;
    logic            go;
    logic            resp_hit;
    logic            expire;
    logic [XLEN-1:0] rdata_ext;

    logic            regwrite_q;
    logic [1:0]      resultsrc_q;
    logic [RD_W-1:0] rd_q;
    logic [XLEN-1:0] alures_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] pc4_q;
    logic            misalign_q;
    logic            buserr_q;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3_i    (Funct3M),
        .addr_lo_i   (ALUResultM[2:0]),
        .wdata_i     (WriteDataM),
        .rdata_i     (mem_resp_rdata),
        .be_o        (mem_req_be),
        .wdata_rep_o (mem_req_wdata),
        .bad_o       (bad),
        .rdata_ext_o (rdata_ext)
    );

    assign access   = MemreadM | MemwriteM;
    assign go       = access & ~bad;
    assign resp_hit = (state_q == ST_WAIT) & mem_resp_valid;
    // A response on the expiry cycle takes priority over the bus error.
    assign expire   = (TIMEOUT != 0) && (state_q == ST_WAIT) && !mem_resp_valid &&
                      (wdog_q == TIMEOUT);

    assign MemStall      = go & ~(resp_hit | expire);
    assign mem_req_valid = rst & go & (state_q != ST_WAIT);
    assign mem_req_we    = MemwriteM;
    assign mem_req_addr  = ALUResultM[ADDR_W-1:0] & ~OFF_MASK;

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = mem_req_ready ? ST_WAIT : ST_REQ;
                    wdog_d  = '0;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                    wdog_d  = '0;
                end
            end
            ST_WAIT: begin
                if (resp_hit || expire) begin
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
        end
    end

    // MEM/WB register: advances whenever the stage is not stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= '0;
            rd_q        <= '0;
            alures_q    <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            misalign_q  <= 1'b0;
            buserr_q    <= 1'b0;
        end else if (!MemStall) begin
            regwrite_q  <= RegwriteM & ~(access & bad) & ~expire;
            resultsrc_q <= ResultSrcM;
            rd_q        <= RdM;
            alures_q    <= ALUResultM;
            rdata_q     <= (MemreadM & resp_hit) ? rdata_ext : '0;
            pc4_q       <= pc_plus4M;
            misalign_q  <= access & bad;
            buserr_q    <= expire;
        end
    end

    assign RegwriteW  = regwrite_q;
    assign ResultSrcW = resultsrc_q;
    assign RdW        = rd_q;
    assign ALUResultW = alures_q;
    assign ReadDataW  = rdata_q;
    assign pc_plus4W  = pc4_q;
    assign MisalignW  = misalign_q;
    assign BusErrW    = buserr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    import mem_stage_pkg::*;

    localparam int unsigned TMO  = 4;
    localparam int unsigned BASE = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegwriteM, MemwriteM, MemreadM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, pc_plus4M;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        MemStall, RegwriteW, MisalignW, BusErrW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW, ReadDataW, pc_plus4W;

    mem_stage_lsu #(
        .XLEN    (32),
        .ADDR_W  (32),
        .RD_W    (5),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RegwriteM      (RegwriteM),
        .ResultSrcM     (ResultSrcM),
        .MemwriteM      (MemwriteM),
        .MemreadM       (MemreadM),
        .Funct3M        (Funct3M),
        .RdM            (RdM),
        .ALUResultM     (ALUResultM),
        .WriteDataM     (WriteDataM),
        .pc_plus4M      (pc_plus4M),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_be     (mem_req_be),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .MemStall       (MemStall),
        .RegwriteW      (RegwriteW),
        .ResultSrcW     (ResultSrcW),
        .RdW            (RdW),
        .ALUResultW     (ALUResultW),
        .ReadDataW      (ReadDataW),
        .pc_plus4W      (pc_plus4W),
        .MisalignW      (MisalignW),
        .BusErrW        (BusErrW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic        mis;
        logic        berr;
        int unsigned stalls;
    } exp_t;

    // kind: 0 = ALU op, 1 = load, 2 = store
    typedef struct {
        int unsigned kind;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc4;
        logic        rw;
        logic [1:0]  rsrc;
        int unsigned rdy;
        int unsigned rsp;
    } ins_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    byte unsigned ref_mem [64];   // reference memory, byte addressed from BASE
    logic [31:0]  cache [16];     // bench cache responder storage

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned nbytes(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit is_bad(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [63:0] v;
        int unsigned n;
        n = nbytes(f3);
        v = '0;
        for (int unsigned i = 0; i < n; i++)
            v = v | (64'(ref_mem[a - BASE + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    function automatic ins_t mk(input int unsigned kind, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int unsigned rdy, input int unsigned rsp);
        ins_t s;
        s.kind = kind; s.f3 = f3; s.addr = addr; s.wdata = wdata;
        s.rdy = rdy; s.rsp = rsp;
        s.rd = 5'd5; s.rw = (kind != 2); s.rsrc = 2'd1; s.pc4 = 32'h0000_2004;
        return s;
    endfunction

    function automatic ins_t rand_ins();
        ins_t s;
        int unsigned r, k;
        r = $urandom_range(0, 9);
        s.kind = (r < 3) ? 0 : ((r < 7) ? 1 : 2);
        if (s.kind == 2) begin
            k = $urandom_range(0, 4);
            s.f3 = (k == 4) ? 3'd7 : 3'(k);
        end else begin
            s.f3 = 3'($urandom_range(0, 7));
        end
        s.addr = BASE + $urandom_range(0, 60);
        if (s.kind != 0 && $urandom_range(0, 3) != 0)
            s.addr = s.addr & ~(nbytes(s.f3) - 1);
        s.rd    = 5'($urandom);
        s.wdata = $urandom;
        s.pc4   = $urandom;
        s.rw    = (s.kind == 2) ? 1'b0 : 1'($urandom);
        s.rsrc  = 2'($urandom);
        s.rdy   = $urandom_range(0, 3);
        r = $urandom_range(0, 9);
        s.rsp = (r < 7) ? $urandom_range(0, 3) : ((r < 9) ? TMO : TMO + 2);
        return s;
    endfunction

    // Issues one instruction, plays the cache side, and pushes the expected
    // MEM/WB contents. Called at a negedge; returns at the negedge after retire.
    task automatic run_ins(input ins_t ins, input bit stale);
        exp_t        e;
        bit          acc, bad, berr;
        int unsigned n, lim, idx, off;
        logic [3:0]  exp_be, cap_be;
        logic [31:0] exp_wd, cap_wd, exp_addr;

        RegwriteM  = ins.rw;       ResultSrcM = ins.rsrc;
        MemwriteM  = (ins.kind == 2);
        MemreadM   = (ins.kind == 1);
        Funct3M    = ins.f3;       RdM        = ins.rd;
        ALUResultM = ins.addr;     WriteDataM = ins.wdata;
        pc_plus4M  = ins.pc4;
        mem_req_ready  = 1'b0;
        mem_resp_valid = stale;
        mem_resp_rdata = $urandom;

        acc  = (ins.kind != 0);
        n    = nbytes(ins.f3);
        bad  = acc && is_bad(ins.f3, ins.addr);
        berr = acc && !bad && (ins.rsp > TMO);
        lim  = (ins.rsp > TMO) ? TMO : ins.rsp;

        e.rw     = ins.rw && !bad && !berr;
        e.rsrc   = ins.rsrc;
        e.rd     = ins.rd;
        e.alu    = ins.addr;
        e.pc4    = ins.pc4;
        e.mis    = bad;
        e.berr   = berr;
        e.rdata  = (ins.kind == 1 && !bad && !berr) ? ref_load(ins.f3, ins.addr) : 32'd0;
        e.stalls = (acc && !bad) ? ins.rdy + 1 + lim : 0;
        if (ins.kind == 2 && !bad && !berr)
            for (int unsigned i = 0; i < n; i++)
                ref_mem[ins.addr - BASE + i] = ins.wdata[8 * i +: 8];
        sb_q.push_back(e);

        if (!acc || bad) begin
            #2 check("idle_req_valid", mem_req_valid, 1'b0);
            @(negedge clk);
            mem_resp_valid = 1'b0;
            return;
        end

        off      = ins.addr % 4;
        exp_addr = ins.addr & ~32'h3;
        for (int unsigned b = 0; b < 4; b++) begin
            exp_be[b]         = (b >= off) && (b < off + n);
            exp_wd[8 * b +: 8] = ins.wdata[8 * (b % n) +: 8];
        end

        for (int unsigned c = 0; c <= ins.rdy; c++) begin
            if (c > 0) @(negedge clk);
            mem_req_ready = (c == ins.rdy);
            #2;
            check("req_valid", mem_req_valid, 1'b1);
            check("req_addr", mem_req_addr, exp_addr);
            check("req_be", mem_req_be, exp_be);
            check("req_we", mem_req_we, ins.kind == 2);
            if (ins.kind == 2) check("req_wdata", mem_req_wdata, exp_wd);
        end
        cap_wd = mem_req_wdata;
        cap_be = mem_req_be;
        idx    = ((mem_req_addr - BASE) >> 2) & 32'hF;

        for (int unsigned w = 0; w <= lim; w++) begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = (w == ins.rsp);
            if (w == ins.rsp) begin
                mem_resp_rdata = cache[idx];
                if (ins.kind == 2)
                    for (int unsigned b = 0; b < 4; b++)
                        if (cap_be[b]) cache[idx][8 * b +: 8] = cap_wd[8 * b +: 8];
            end else begin
                mem_resp_rdata = $urandom;
            end
            #2 check("wait_req_valid", mem_req_valid, 1'b0);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
    endtask

    // Monitor: watches MemStall before each edge and compares MEM/WB after it.
    initial begin : monitor
        int unsigned stall_cnt;
        logic        s_rst, s_stall;
        exp_t        e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            s_rst   = rst;
            s_stall = MemStall;
            if (!s_rst) check("rst_req_valid", mem_req_valid, 1'b0);
            @(posedge clk);
            #1;
            if (!s_rst) begin
                stall_cnt = 0;
                check("rst_W_outputs",
                      |{RegwriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, pc_plus4W,
                        MisalignW, BusErrW}, 1'b0);
            end else if (s_stall) begin
                stall_cnt++;
            end else if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_retire: got a retire, expected none at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("RegwriteW", RegwriteW, e.rw);
                check("ResultSrcW", ResultSrcW, e.rsrc);
                check("RdW", RdW, e.rd);
                check("ALUResultW", ALUResultW, e.alu);
                check("ReadDataW", ReadDataW, e.rdata);
                check("pc_plus4W", pc_plus4W, e.pc4);
                check("MisalignW", MisalignW, e.mis);
                check("BusErrW", BusErrW, e.berr);
                check("stall_cycles", stall_cnt, e.stalls);
                stall_cnt = 0;
            end
        end
    end

    initial begin : global_timeout
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, expected end");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] w;
        rst = 1'b0;
        RegwriteM = 1'b0; ResultSrcM = '0; MemwriteM = 1'b0; MemreadM = 1'b0;
        Funct3M = '0; RdM = '0; ALUResultM = '0; WriteDataM = '0; pc_plus4M = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

        for (int unsigned i = 0; i < 16; i++) begin
            w = (i == 0) ? 32'h8000_0000 : $urandom;
            cache[i] = w;
            for (int unsigned b = 0; b < 4; b++) ref_mem[4 * i + b] = w[8 * b +: 8];
        end

        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_ins(mk(0, F3_B,  32'h0000_1234, 32'h0,      0, 0),     1'b0);
        run_ins(mk(1, F3_B,  32'h0000_0103, 32'h0,      0, 0),     1'b0);
        run_ins(mk(1, F3_BU, 32'h0000_0103, 32'h0,      0, 0),     1'b0);
        run_ins(mk(2, F3_H,  32'h0000_0102, 32'hABCD,   3, 0),     1'b0);
        run_ins(mk(1, F3_W,  32'h0000_0102, 32'h0,      0, 0),     1'b0);
        run_ins(mk(1, F3_W,  32'h0000_0104, 32'h0,      0, TMO + 2), 1'b0);
        run_ins(mk(1, F3_W,  32'h0000_0104, 32'h0,      0, TMO),   1'b0);
        run_ins(mk(1, F3_H,  32'h0000_0102, 32'h0,      1, 2),     1'b0);
        run_ins(mk(1, F3_HU, 32'h0000_0102, 32'h0,      0, 1),     1'b0);

        for (int unsigned k = 0; k < 300; k++) run_ins(rand_ins(), 1'b0);

        // Reset while a load sits in WAIT; its late response must be ignored.
        RegwriteM = 1'b1; ResultSrcM = 2'd1; MemwriteM = 1'b0; MemreadM = 1'b1;
        Funct3M = F3_W; RdM = 5'd7; ALUResultM = 32'h0000_0108;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        MemreadM = 1'b0; RegwriteM = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_ins(mk(0, F3_B, 32'h0000_0555, 32'h0, 0, 0), 1'b1);
        run_ins(mk(1, F3_W, 32'h0000_0108, 32'h0, 1, 1), 1'b0);

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
